alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue register for the pipeline; produces the operand/control inputs the Alu consumes.
//  - Decodes a MIPS instruction into a 4-bit `ALU_* op code (macro.vh).
//  - Builds the two ALU operands r and s, and the register-write target.
//  - Registers all of it into the EX stage, with stall and flush control.
// PARAMETERS
//  DW      32  datapath width; o_alu_r and o_alu_s are DW bits.
//  RAW     5   register-address width.
// PORTS
//  i_clk        in   1    clock, rising edge
//  i_rst        in   1    reset, asynchronous, active-high
//  i_valid      in   1    i_instr and operand data are valid this cycle
//  i_instr      in   32   instruction word
//  i_rs_data    in   DW   register-file read data for rs
//  i_rt_data    in   DW   register-file read data for rt
//  i_stall      in   1    hold the EX register contents
//  i_flush      in   1    kill the EX register contents (insert a bubble)
//  o_valid      out  1    EX slot holds an instruction
//  o_aluc       out  4    ALU op code, `ALU_* encoding
//  o_alu_r      out  DW   ALU r operand
//  o_alu_s      out  DW   ALU s operand
//  o_wreg_addr  out  RAW  destination register
//  o_wreg_en    out  1    write-back enable
//  o_illegal    out  1    EX slot holds an undecodable instruction
// BEHAVIOUR
//  Reset: every output is 0 (o_aluc = 4'h0).
//  Latency: 1 cycle from i_valid/i_instr to the registered outputs.
//  Register update priority, evaluated each clock edge:
//   1. i_flush: o_valid=0, o_wreg_en=0, o_illegal=0; payload don't-care. Flush wins over stall.
//   2. i_stall (and no flush): every output holds its value.
//   3. Otherwise: load the decode result. o_valid=i_valid.
//      o_wreg_en = i_valid & legal & (dest!=0).
//      o_illegal = i_valid & ~legal.
//  R-type (op=0), funct to op code:
//   20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
//   00/04 SLL, 02/06 SRL, 03/07 SRA
//   dest = rd.
//  R-type operands:
//   - Non-shift ops: r=rs_data, s=rt_data.
//   - Fixed shifts (00/02/03): r = zero-extended shamt[10:6], s=rt_data.
//   - Variable shifts (04/06/07): r = zero-extended rs_data[4:0], s=rt_data.
//  I-type, opcode to op code:
//   08 ADD, 09 ADDU, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR, 0F LUI
//   dest = rt, r = rs_data.
//  I-type immediate handling:
//   - Sign-extended imm16 for 08-0B.
//   - Zero-extended imm16 for 0C-0E.
//   - LUI: r=0, s=zero-extended imm16 (the ALU applies the <<16).
//  Any other op/funct: legal=0, o_aluc=4'h0, r=s=0.
//  i_valid=0 and no stall: a bubble loads (o_valid=0, o_wreg_en=0).
//  Reset asserted mid-operation clears the EX slot immediately, with no clock edge needed.
// CONFIGURATION
//  ALU_ISSUE_FWD_EN defined:
//   - Adds ports i_fwd_wen (1), i_fwd_waddr (RAW), i_fwd_wdata (DW).
//   - If i_fwd_wen & i_fwd_waddr!=0 & i_fwd_waddr==rs (or rt), that operand source uses i_fwd_wdata
//     instead of i_rs_data / i_rt_data, before any shift/immediate selection.
//   - rs and rt are forwarded independently.
//  ALU_ISSUE_FWD_EN undefined: the ports are absent; operands always come from i_rs_data / i_rt_data.
// TESTING
//  1. add $3,$1,$2 with rs=5, rt=7, valid -> next cycle: o_aluc=`ALU_ADD, r=5, s=7,
//     o_wreg_addr=3, o_wreg_en=1, o_valid=1.
//  2. addi imm=FFFF -> s=FFFFFFFF; andi imm=FFFF -> s=0000FFFF;
//     lui imm=1234 -> o_aluc=`ALU_LUI, r=0, s=00001234.
//  3. sll $4,$2,4 with rt=1 -> r=4, s=1, o_aluc=`ALU_SLL;
//     srav with rs=0x23 -> r=3, o_aluc=`ALU_SRA.
//  4. i_stall held 3 cycles while i_instr changes -> outputs unchanged;
//     assert stall+flush together -> o_valid=0 next cycle.
//  5. op=3F -> o_illegal=1, o_wreg_en=0, o_valid=1;
//     add with rd=0 -> o_wreg_en=0.
//  6. Assert i_rst mid-stream between edges -> all outputs 0 immediately.
//     With ALU_ISSUE_FWD_EN: fwd waddr=1, wdata=99, add $3,$1,$1 -> r=s=99.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes a MIPS instruction into an ALU op code plus operands,
// and holds them for EX under stall/flush control. Define ALU_ISSUE_FWD_EN to add a forwarding port.
`ifndef ALU_ADD
`define ALU_NOP  4'h0
`define ALU_ADD  4'h1
`define ALU_ADDU 4'h2
`define ALU_SUB  4'h3
`define ALU_SUBU 4'h4
`define ALU_AND  4'h5
`define ALU_OR   4'h6
`define ALU_XOR  4'h7
`define ALU_NOR  4'h8
`define ALU_SLT  4'h9
`define ALU_SLTU 4'hA
`define ALU_SLL  4'hB
`define ALU_SRL  4'hC
`define ALU_SRA  4'hD
`define ALU_LUI  4'hE
`endif

module alu_issue_stage #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  input  logic [31:0]    i_instr,
  input  logic [DW-1:0]  i_rs_data,
  input  logic [DW-1:0]  i_rt_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic           i_fwd_wen,
  input  logic [RAW-1:0] i_fwd_waddr,
  input  logic [DW-1:0]  i_fwd_wdata,
`endif
  input  logic           i_stall,
  input  logic           i_flush,
  output logic           o_valid,
  output logic [3:0]     o_aluc,
  output logic [DW-1:0]  o_alu_r,
  output logic [DW-1:0]  o_alu_s,
  output logic [RAW-1:0] o_wreg_addr,
  output logic           o_wreg_en,
  output logic           o_illegal
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = i_instr[31:26];
  assign rs    = i_instr[25:21];
  assign rt    = i_instr[20:16];
  assign rd    = i_instr[15:11];
  assign shamt = i_instr[10:6];
  assign funct = i_instr[5:0];
  assign imm   = i_instr[15:0];

  logic [DW-1:0] rs_src, rt_src;

`ifdef ALU_ISSUE_FWD_EN
  // Bypass a write-back still in flight; $0 is never forwarded.
  always_comb begin
    rs_src = i_rs_data;
    rt_src = i_rt_data;
    if (i_fwd_wen && (i_fwd_waddr != '0) && (i_fwd_waddr == RAW'(rs))) rs_src = i_fwd_wdata;
    if (i_fwd_wen && (i_fwd_waddr != '0) && (i_fwd_waddr == RAW'(rt))) rt_src = i_fwd_wdata;
  end
`else
  assign rs_src = i_rs_data;
  assign rt_src = i_rt_data;
`endif

  logic           dec_legal;
  logic [3:0]     dec_aluc;
  logic [DW-1:0]  dec_r, dec_s;
  logic [RAW-1:0] dec_dest;
  logic [DW-1:0]  imm_sx, imm_zx;

  assign imm_sx = {{(DW-16){imm[15]}}, imm};
  assign imm_zx = {{(DW-16){1'b0}}, imm};

  always_comb begin
    dec_legal = 1'b0;
    dec_aluc  = `ALU_NOP;
    dec_r     = '0;
    dec_s     = '0;
    dec_dest  = '0;
    if (op == 6'h00) begin
      dec_legal = 1'b1;
      dec_dest  = RAW'(rd);
      dec_r     = rs_src;
      dec_s     = rt_src;
      case (funct)
        6'h20: dec_aluc = `ALU_ADD;
        6'h21: dec_aluc = `ALU_ADDU;
        6'h22: dec_aluc = `ALU_SUB;
        6'h23: dec_aluc = `ALU_SUBU;
        6'h24: dec_aluc = `ALU_AND;
        6'h25: dec_aluc = `ALU_OR;
        6'h26: dec_aluc = `ALU_XOR;
        6'h27: dec_aluc = `ALU_NOR;
        6'h2A: dec_aluc = `ALU_SLT;
        6'h2B: dec_aluc = `ALU_SLTU;
        6'h00, 6'h02, 6'h03: begin
          dec_aluc = (funct == 6'h00) ? `ALU_SLL : (funct == 6'h02) ? `ALU_SRL : `ALU_SRA;
          dec_r    = {{(DW-5){1'b0}}, shamt};
        end
        6'h04, 6'h06, 6'h07: begin
          dec_aluc = (funct == 6'h04) ? `ALU_SLL : (funct == 6'h06) ? `ALU_SRL : `ALU_SRA;
          dec_r    = {{(DW-5){1'b0}}, rs_src[4:0]};
        end
        default: begin
          dec_legal = 1'b0;
          dec_r     = '0;
          dec_s     = '0;
        end
      endcase
    end else if (op[5:3] == 3'b001) begin
      dec_legal = 1'b1;
      dec_dest  = RAW'(rt);
      dec_r     = rs_src;
      case (op[2:0])
        3'h0: begin dec_aluc = `ALU_ADD;  dec_s = imm_sx; end
        3'h1: begin dec_aluc = `ALU_ADDU; dec_s = imm_sx; end
        3'h2: begin dec_aluc = `ALU_SLT;  dec_s = imm_sx; end
        3'h3: begin dec_aluc = `ALU_SLTU; dec_s = imm_sx; end
        3'h4: begin dec_aluc = `ALU_AND;  dec_s = imm_zx; end
        3'h5: begin dec_aluc = `ALU_OR;   dec_s = imm_zx; end
        3'h6: begin dec_aluc = `ALU_XOR;  dec_s = imm_zx; end
        default: begin
          // The ALU applies the <<16 for LUI.
          dec_aluc = `ALU_LUI;
          dec_r    = '0;
          dec_s    = imm_zx;
        end
      endcase
    end
  end

  logic           valid_q, valid_d;
  logic [3:0]     aluc_q, aluc_d;
  logic [DW-1:0]  r_q, r_d, s_q, s_d;
  logic [RAW-1:0] waddr_q, waddr_d;
  logic           wen_q, wen_d;
  logic           illegal_q, illegal_d;

  always_comb begin
    valid_d   = valid_q;
    aluc_d    = aluc_q;
    r_d       = r_q;
    s_d       = s_q;
    waddr_d   = waddr_q;
    wen_d     = wen_q;
    illegal_d = illegal_q;
    if (i_flush) begin
      // Flush beats stall; payload is left as-is since nothing consumes it.
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      illegal_d = 1'b0;
    end else if (!i_stall) begin
      valid_d   = i_valid;
      aluc_d    = dec_aluc;
      r_d       = dec_r;
      s_d       = dec_s;
      waddr_d   = dec_dest;
      wen_d     = i_valid & dec_legal & (dec_dest != '0);
      illegal_d = i_valid & ~dec_legal;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      aluc_q    <= 4'h0;
      r_q       <= '0;
      s_q       <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      aluc_q    <= aluc_d;
      r_q       <= r_d;
      s_q       <= s_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_aluc      = aluc_q;
  assign o_alu_r     = r_q;
  assign o_alu_s     = s_q;
  assign o_wreg_addr = waddr_q;
  assign o_wreg_en   = wen_q;
  assign o_illegal   = illegal_q;

endmodule
